// File: rtl/req_initiator.sv
// Initiator end of the valid/ready request bus: runs one local command as a
// single bus transfer and returns its result, aborting after TIMEOUT cycles without ready.
module req_initiator #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              valid,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              ready,
    input  logic [DATA_W-1:0] rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [7:0]        txn_cnt
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // REQ   | bus request driven, waiting for ready or timeout
    // RSP   | response presented, waiting for rsp_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tmo_cnt;
    logic       accept;
    logic       done_ok;
    logic       done_tmo;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        valid     = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        done_ok   = 1'b0;
        done_tmo  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                valid = 1'b1;
                // ready in the last timeout cycle still counts as success
                if (ready) begin
                    done_ok   = 1'b1;
                    state_nxt = RSP;
                end else if (tmo_cnt == TMO_LAST) begin
                    done_tmo  = 1'b1;
                    state_nxt = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            write     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            txn_cnt   <= 8'd0;
            tmo_cnt   <= 8'd0;
        end else begin
            if (accept) begin
                write   <= cmd_write;
                addr    <= cmd_addr;
                wdata   <= cmd_wdata;
                tmo_cnt <= 8'd0;
            end
            if (done_ok) begin
                rsp_rdata <= write ? '0 : rdata;
                rsp_err   <= 1'b0;
                txn_cnt   <= txn_cnt + 8'd1;
            end else if (done_tmo) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
                txn_cnt   <= txn_cnt + 8'd1;
            end else if (state == REQ) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_req_initiator.sv
// Directed bench for req_initiator: a transaction-schedule model predicts every
// output each cycle; literal checks pin latency, valid length and response data.
module tb_req_initiator;

    localparam int TO = 15;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [3:0] cmd_addr = 4'h0;
    logic [3:0] cmd_wdata = 4'h0;
    logic       valid;
    logic       write;
    logic [3:0] addr;
    logic [3:0] wdata;
    logic       ready = 1'b0;
    logic [3:0] rdata = 4'h0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] txn_cnt;

    req_initiator #(.ADDR_W(4), .DATA_W(4), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .valid(valid), .write(write), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .txn_cnt(txn_cnt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    // Model: one transaction record. Accepted at edge t_acc, valid for n cycles,
    // then response for h+1 cycles; base is txn_cnt before this transaction.
    bit         chk_en = 1'b0;
    bit         rec_on = 1'b0;
    int         t_acc = 0;
    int         n = 0;
    int         h = 0;
    int         base = 0;
    logic       m_write = 1'b0;
    logic [3:0] m_addr = 4'h0;
    logic [3:0] m_wdata = 4'h0;
    logic [3:0] m_rdata = 4'h0;
    logic       m_err = 1'b0;

    int         obs_acc = 0;
    int         obs_nvalid = 0;
    int         obs_rsp_cycles = 0;
    int         obs_lat = 0;
    int         obs_txn = 0;
    bit         obs_seen = 1'b0;
    logic [3:0] obs_rdata = 4'h0;
    logic       obs_err = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin : cmp
        int rel;
        bit in_req;
        bit in_rsp;
        int exp_txn;
        rel     = cyc - t_acc;
        in_req  = rec_on && rel >= 0 && rel < n;
        in_rsp  = rec_on && rel >= n && rel <= n + h;
        exp_txn = (base + ((rec_on && rel >= n) ? 1 : 0)) % 256;
        if (chk_en) begin
            chk("cmd_ready", int'(cmd_ready), int'(!(in_req || in_rsp)));
            chk("valid", int'(valid), int'(in_req));
            chk("rsp_valid", int'(rsp_valid), int'(in_rsp));
            chk("txn_cnt", int'(txn_cnt), exp_txn);
            chk("write", int'(write), int'(m_write));
            chk("addr", int'(addr), int'(m_addr));
            chk("wdata", int'(wdata), int'(m_wdata));
            if (in_rsp) begin
                chk("rsp_rdata", int'(rsp_rdata), int'(m_rdata));
                chk("rsp_err", int'(rsp_err), int'(m_err));
            end
        end
        if (valid) obs_nvalid++;
        if (rsp_valid) begin
            obs_rsp_cycles++;
            if (!obs_seen) begin
                obs_seen  = 1'b1;
                obs_lat   = cyc - obs_acc;
                obs_rdata = rsp_rdata;
                obs_err   = rsp_err;
                obs_txn   = int'(txn_cnt);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Called in an idle cycle: presents the command and records the expected schedule.
    task automatic issue(input logic w, input logic [3:0] a, input logic [3:0] wd,
                         input int d, input int hh, input logic [3:0] rd);
        base     = (base + (rec_on ? 1 : 0)) % 256;
        rec_on   = 1'b1;
        t_acc    = cyc + 1;
        n        = (d < TO) ? d + 1 : TO;
        h        = hh;
        m_write  = w;
        m_addr   = a;
        m_wdata  = wd;
        m_err    = (d >= TO);
        m_rdata  = (d >= TO || w) ? 4'h0 : rd;
        obs_acc        = cyc;
        obs_nvalid     = 0;
        obs_rsp_cycles = 0;
        obs_seen       = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = wd;
        ready     = 1'b1;
        rdata     = 4'($urandom);
        rsp_ready = 1'b0;
    endtask

    // d: REQ cycles with ready low before ready (d >= TO never asserts it);
    // hh: RSP cycles with rsp_ready low; pulse: stray commands during RSP.
    task automatic run_txn(input logic w, input logic [3:0] a, input logic [3:0] wd,
                           input int d, input int hh, input logic [3:0] rd, input bit pulse);
        int k;
        tick();
        issue(w, a, wd, d, hh, rd);
        do begin
            tick();
            k = cyc - t_acc;
            cmd_valid = pulse && k >= n && k < n + h;
            if (pulse) begin
                cmd_write = 1'($urandom);
                cmd_addr  = 4'($urandom);
                cmd_wdata = 4'($urandom);
            end
            ready     = (k == d) || (k >= n);
            rdata     = (k == d) ? rd : 4'($urandom);
            rsp_ready = (k == n + h);
        end while (k < n + h);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_valid", int'(valid), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_txn", int'(txn_cnt), 0);
        chk("rst_write", int'(write), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_wdata", int'(wdata), 0);
        chk("rst_rsp_rdata", int'(rsp_rdata), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        reset  = 1'b1;
        chk_en = 1'b1;

        run_txn(1'b0, 4'ha, 4'h0, 0, 0, 4'h5, 1'b0);
        chk("rd_lat", obs_lat, 2);
        chk("rd_nvalid", obs_nvalid, 1);
        chk("rd_rdata", int'(obs_rdata), 5);
        chk("rd_err", int'(obs_err), 0);
        chk("rd_txn", obs_txn, 1);

        run_txn(1'b1, 4'h3, 4'h4, 3, 0, 4'hf, 1'b0);
        chk("wr_nvalid", obs_nvalid, 4);
        chk("wr_rdata", int'(obs_rdata), 0);
        chk("wr_err", int'(obs_err), 0);

        run_txn(1'b0, 4'h7, 4'h0, TO, 0, 4'h6, 1'b0);
        chk("tmo_nvalid", obs_nvalid, 15);
        chk("tmo_lat", obs_lat, 16);
        chk("tmo_err", int'(obs_err), 1);
        chk("tmo_rdata", int'(obs_rdata), 0);

        run_txn(1'b0, 4'hc, 4'h0, 0, 0, 4'h2, 1'b0);
        chk("after_tmo_err", int'(obs_err), 0);
        chk("after_tmo_rdata", int'(obs_rdata), 2);

        run_txn(1'b0, 4'h1, 4'h0, TO - 1, 0, 4'h9, 1'b0);
        chk("edge_nvalid", obs_nvalid, 15);
        chk("edge_err", int'(obs_err), 0);
        chk("edge_rdata", int'(obs_rdata), 9);

        run_txn(1'b0, 4'he, 4'h0, 0, 5, 4'hb, 1'b1);
        chk("bp_rsp_cycles", obs_rsp_cycles, 6);
        chk("bp_rdata", int'(obs_rdata), 'hb);
        tick();
        chk("bp_cmd_ready", int'(cmd_ready), 1);

        tick();
        issue(1'b0, 4'h5, 4'h0, TO, 0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        ready     = 1'b0;
        tick();
        chk_en = 1'b0;
        reset  = 1'b0;
        tick();
        chk("rr_valid", int'(valid), 0);
        chk("rr_rsp_valid", int'(rsp_valid), 0);
        chk("rr_cmd_ready", int'(cmd_ready), 1);
        chk("rr_txn", int'(txn_cnt), 0);
        reset   = 1'b1;
        rec_on  = 1'b0;
        base    = 0;
        m_write = 1'b0;
        m_addr  = 4'h0;
        m_wdata = 4'h0;
        chk_en  = 1'b1;

        for (int i = 0; i < 257; i++) begin
            run_txn(1'b0, 4'(i), 4'h0, 0, 0, 4'(i + 3), 1'b0);
        end
        chk("wrap_txn", obs_txn, 1);
        tick();
        tick();
        chk("wrap_txn_idle", int'(txn_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
